// File: rtl/timer_pkg.sv
// Shared types for the multi-mode timer: counting modes, FSM states and irq_clr bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'b00,
        MODE_CTC     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } timer_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fsm_state_e;

    localparam int unsigned IRQ_OVF_BIT = 0;
    localparam int unsigned IRQ_CMP_BIT = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable prescaler: asserts tick once every presc_div+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               clr,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] presc_q, presc_d;

    // A divisor lowered below the current count lets the count wrap through 2^PRESC_W.
    assign tick = en && (presc_q == presc_div);

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/timer_multimode.sv
// Multi-mode timer/counter (NORMAL, CTC, ONESHOT) with prescaler, preload and sticky irq flags.
// Define TIMER_PWM_EN to add the registered pwm_out port and its comparator.
module timer_multimode
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic [WIDTH-1:0]   cmp_val,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [1:0]         irq_clr,
    output logic [WIDTH-1:0]   timer_cnt,
    output logic               irq_ovf,
    output logic               irq_cmp,
    output logic               running
`ifdef TIMER_PWM_EN
    ,
    output logic               pwm_out
`endif
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    fsm_state_e       state_q, state_d;
    timer_mode_e      mode_e;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             cmpf_q, cmpf_d;
    logic             en_q;
    logic             going, tick, hit, restart, done_hit, presc_clr;
    logic             ovf_set, cmp_set;

    assign mode_e    = timer_mode_e'(mode);
    // The enable cycle that leaves IDLE already counts, so ticks start with the first en cycle.
    assign going     = en && (state_q != ST_DONE);
    assign hit       = (cnt_q == cmp_val);
    assign restart   = (state_q == ST_DONE) && en && !en_q && !load;
    assign done_hit  = tick && !load && (mode_e == MODE_ONESHOT) && hit;
    assign presc_clr = load || restart;

    timer_prescaler #(
        .PRESC_W(PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (going),
        .presc_div(presc_div),
        .clr      (presc_clr),
        .tick     (tick)
    );

    // Load suppresses both the counter step and the flags of a coincident tick.
    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        cmp_set = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (restart) begin
            cnt_d = '0;
        end else if (tick) begin
            cmp_set = hit;
            if (hit && (mode_e == MODE_CTC)) begin
                cnt_d = '0;
            end else if (hit && (mode_e == MODE_ONESHOT)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
                ovf_set = (cnt_q == '1);
            end
        end
    end

    assign ovf_d  = ovf_set | (ovf_q & ~irq_clr[IRQ_OVF_BIT]);
    assign cmpf_d = cmp_set | (cmpf_q & ~irq_clr[IRQ_CMP_BIT]);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (done_hit) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load || (en && !en_q)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            cmpf_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            cmpf_q  <= cmpf_d;
            en_q    <= en;
        end
    end

    assign timer_cnt = cnt_q;
    assign irq_ovf   = ovf_q;
    assign irq_cmp   = cmpf_q;
    assign running   = (state_q == ST_RUN);

`ifdef TIMER_PWM_EN
    logic pwm_d, pwm_q;

    assign pwm_d = (state_q != ST_IDLE) && (mode_e != MODE_ONESHOT) && (cnt_q < cmp_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_timer_multimode.sv
// Self-checking bench for timer_multimode (WIDTH=8, PRESC_W=4): directed cases plus random traffic
// checked every cycle against a cycle-level behavioural model; pwm_out checked under TIMER_PWM_EN.
module tb_timer_multimode;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [PW-1:0] presc_div = '0;
    logic [W-1:0]  cmp_val = '0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [1:0]    irq_clr = 2'b00;
    logic [W-1:0]  timer_cnt;
    logic          irq_ovf, irq_cmp, running;
    logic          pwm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_multimode #(
        .WIDTH  (W),
        .PRESC_W(PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .presc_div(presc_div),
        .cmp_val  (cmp_val),
        .load     (load),
        .load_val (load_val),
        .irq_clr  (irq_clr),
        .timer_cnt(timer_cnt),
        .irq_ovf  (irq_ovf),
        .irq_cmp  (irq_cmp),
        .running  (running)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out  (pwm)
`endif
    );

`ifndef TIMER_PWM_EN
    assign pwm = 1'b0;
`endif

    // Model state: count, prescaler phase, flags, whether counting (run) or stopped at terminal (done).
    typedef struct {
        int cnt;
        int p;
        bit ovf;
        bit cmpf;
        bit run;
        bit done;
        bit pwm;
        bit en_prev;
    } mstate_t;

    mstate_t m_cur, m_nxt;
    bit      valid = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n;
        int  md;
        bit  going, tick, rise, hit, finish, set_o, set_c;
        n = s;
        if (reset) begin
            n = '{default: 0};
            return n;
        end
        md     = (mode == 2'd3) ? 0 : int'(mode);
        n.pwm  = ((s.run || s.done) && md != 2) ? (s.cnt < int'(cmp_val)) : 1'b0;
        going  = en && !s.done;
        tick   = going && (s.p == int'(presc_div));
        rise   = en && !s.en_prev;
        finish = 1'b0;
        set_o  = 1'b0;
        set_c  = 1'b0;
        if (load) begin
            n.cnt = int'(load_val);
            n.p   = 0;
        end else if (s.done && rise) begin
            n.cnt = 0;
            n.p   = 0;
        end else if (going) begin
            n.p = tick ? 0 : (s.p + 1) % (1 << PW);
            if (tick) begin
                hit   = (s.cnt == int'(cmp_val));
                set_c = hit;
                if (hit && md == 1) n.cnt = 0;
                else if (hit && md == 2) finish = 1'b1;
                else begin
                    set_o = (s.cnt == (1 << W) - 1);
                    n.cnt = (s.cnt + 1) % (1 << W);
                end
            end
        end
        n.ovf  = set_o || (s.ovf && !irq_clr[0]);
        n.cmpf = set_c || (s.cmpf && !irq_clr[1]);
        if (s.done) begin
            if (load || rise) begin
                n.run  = 1'b1;
                n.done = 1'b0;
            end
        end else if (finish) begin
            n.run  = 1'b0;
            n.done = 1'b1;
        end else begin
            n.run = en;
        end
        n.en_prev = en;
        return n;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            m_nxt = model_next(m_cur);
            @(posedge clk);
            m_cur = m_nxt;
            valid = 1'b1;
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; irq_clr = 2'b00;
        step(1);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            chk("model_cnt", int'(timer_cnt), m_cur.cnt);
            chk("model_ovf", int'(irq_ovf), int'(m_cur.ovf));
            chk("model_cmp", int'(irq_cmp), int'(m_cur.cmpf));
            chk("model_running", int'(running), int'(m_cur.run));
`ifdef TIMER_PWM_EN
            chk("model_pwm", int'(pwm), int'(m_cur.pwm));
`endif
        end
    end

    initial begin
        step(2);
        reset = 1'b0;
        chk("reset_cnt", int'(timer_cnt), 0);
        chk("reset_flags", int'({irq_ovf, irq_cmp}), 0);
        chk("reset_running", int'(running), 0);

        // NORMAL, divide-by-1: wrap on the 256th enabled cycle, flag sticky until cleared.
        mode = 2'd0; presc_div = 4'd0; cmp_val = 8'd200; en = 1'b1;
        step(255);
        chk("t1_cnt_255", int'(timer_cnt), 255);
        chk("t1_no_ovf_yet", int'(irq_ovf), 0);
        step(1);
        chk("t1_wrap_cnt", int'(timer_cnt), 0);
        chk("t1_ovf_set", int'(irq_ovf), 1);
        step(5);
        chk("t1_ovf_sticky", int'(irq_ovf), 1);
        irq_clr = 2'b01; step(1); irq_clr = 2'b00;
        chk("t1_ovf_cleared", int'(irq_ovf), 0);

        // NORMAL, divide-by-4 over 40 cycles.
        do_reset();
        mode = 2'd0; presc_div = 4'd3; cmp_val = 8'd200; en = 1'b1;
        step(40);
        chk("t2_cnt", int'(timer_cnt), 10);
        chk("t2_ovf", int'(irq_ovf), 0);

        // CTC at 9: 0..9,0 and clear colliding with set keeps the flag.
        do_reset();
        mode = 2'd1; presc_div = 4'd0; cmp_val = 8'd9; en = 1'b1;
        step(9);
        chk("t3_cnt9", int'(timer_cnt), 9);
        chk("t3_cmp_not_yet", int'(irq_cmp), 0);
        step(1);
        chk("t3_cnt_clear", int'(timer_cnt), 0);
        chk("t3_cmp_set", int'(irq_cmp), 1);
        step(9);
        irq_clr = 2'b10; step(1); irq_clr = 2'b00;
        chk("t3_set_beats_clr", int'(irq_cmp), 1);
        irq_clr = 2'b10; step(1); irq_clr = 2'b00;
        chk("t3_cmp_cleared", int'(irq_cmp), 0);

        // ONESHOT at 5, restart by load and by en edge.
        do_reset();
        mode = 2'd2; presc_div = 4'd0; cmp_val = 8'd5; en = 1'b1;
        step(6);
        chk("t4_cnt_stop", int'(timer_cnt), 5);
        chk("t4_cmp", int'(irq_cmp), 1);
        chk("t4_done", int'(running), 0);
        step(3);
        chk("t4_hold", int'(timer_cnt), 5);
        load = 1'b1; load_val = 8'd2; step(1); load = 1'b0;
        chk("t4_load_cnt", int'(timer_cnt), 2);
        chk("t4_load_run", int'(running), 1);
        step(3);
        chk("t4_recount", int'(timer_cnt), 5);
        step(1);
        chk("t4_done_again", int'(running), 0);
        en = 1'b0; step(1); en = 1'b1; step(1);
        chk("t4_rise_clear", int'(timer_cnt), 0);
        chk("t4_rise_run", int'(running), 1);

        // Reset mid-count, then load colliding with a matching tick.
        do_reset();
        mode = 2'd0; presc_div = 4'd0; cmp_val = 8'h33; en = 1'b1;
        load = 1'b1; load_val = 8'h30; step(1); load = 1'b0;
        step(7);
        chk("t5_cnt37", int'(timer_cnt), 'h37);
        chk("t5_cmp_before", int'(irq_cmp), 1);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("t5_reset_cnt", int'(timer_cnt), 0);
        chk("t5_reset_flags", int'({irq_ovf, irq_cmp}), 0);
        chk("t5_reset_run", int'(running), 0);
        cmp_val = 8'd3; step(3);
        load = 1'b1; load_val = 8'hA5; step(1); load = 1'b0;
        chk("t5_load_wins", int'(timer_cnt), 'hA5);
        chk("t5_no_flag", int'(irq_cmp), 0);

`ifdef TIMER_PWM_EN
        begin
            int highs;
            do_reset();
            mode = 2'd0; presc_div = 4'd0; cmp_val = 8'd64; en = 1'b1;
            step(256);
            highs = 0;
            for (int i = 0; i < 256; i++) begin
                step(1);
                highs += int'(pwm);
            end
            chk("t6_pwm_duty", highs, 64);
        end
`endif

        // Random traffic; the negedge process compares against the model each cycle.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                presc_div = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 79) == 0)
                cmp_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            load     = ($urandom_range(0, 39) == 0);
            load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(245, 255)) : 8'($urandom);
            irq_clr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(1);
        end
        reset = 1'b0; load = 1'b0; irq_clr = 2'b00;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
